traffic_phase_timer: RTL and testbench

Upstream timing stage for the traffic-light state machine. Runs on the free-running system clock and watches the light outputs fed back from the state machine. It holds each phase for a programmed number of seconds, then issues a one-cycle `advance` pulse that drives the state machine's `en` step input. It also synchronises and debounces the raw pedestrian button into a latched `pedReq` level that drives the state machine's `pedToggle`.

---
 rtl/traffic_phase_timer_pkg.sv | 31 +++
 rtl/traffic_phase_timer_ped_debounce.sv | 48 ++++
 rtl/traffic_phase_timer.sv | 149 ++++++++++++++
 tb/tb_traffic_phase_timer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_phase_timer_pkg.sv
// rtl/traffic_phase_timer_pkg.sv - shared phase/timer types and light-vector decode
package traffic_pkg;

   typedef enum logic [2:0] {GREEN, YELLOW, ALLRED, PED, INVALID} phase_class_e;
   typedef enum logic [1:0] {SETTLE, LOAD, COUNT, WAIT_CHG} timer_state_e;

   localparam int SETTLE_CYC = 3;

   // Light vector order: {MG, MY, MR, SG, SY, SR, pedLight}; first match wins.
   function automatic phase_class_e decodeClass(input logic [6:0] lights);
      phase_class_e c;
      if (lights[0])
         c = PED;
      else if (lights[6] | lights[3])
         c = GREEN;
      else if (lights[5] | lights[2])
         c = YELLOW;
      else if (lights[4] & lights[1])
         c = ALLRED;
      else
         c = INVALID;
      return c;
   endfunction

   function automatic logic [7:0] clampDur(input int unsigned seconds);
      logic [7:0] d;
      d = 8'(seconds);
      return (d == 8'd0) ? 8'd1 : d;
   endfunction

endpackage

// File: rtl/traffic_phase_timer_ped_debounce.sv
// rtl/traffic_phase_timer_ped_debounce.sv - button synchroniser, debounce and request latch
module ped_debounce #(
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic pedButton,
   input  logic clear,
   output logic pedReq
);

   localparam int CW = $clog2(DEBOUNCE_CYC + 1);

   logic          btnMeta;
   logic          btnSync;
   logic          debLevel;
   logic          debPrev;
   logic [CW-1:0] stableCnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btnMeta   <= 1'b0;
         btnSync   <= 1'b0;
         debLevel  <= 1'b0;
         debPrev   <= 1'b0;
         stableCnt <= '0;
         pedReq    <= 1'b0;
      end else begin
         btnMeta <= pedButton;
         btnSync <= btnMeta;
         debPrev <= debLevel;
         // Any return to the accepted level restarts the stability window.
         if (btnSync == debLevel) begin
            stableCnt <= '0;
         end else if (stableCnt == CW'(DEBOUNCE_CYC - 1)) begin
            debLevel  <= btnSync;
            stableCnt <= '0;
         end else begin
            stableCnt <= stableCnt + CW'(1);
         end
         if (clear)
            pedReq <= 1'b0;
         else if (debLevel & ~debPrev)
            pedReq <= 1'b1;
      end
   end

endmodule

// File: rtl/traffic_phase_timer.sv
// rtl/traffic_phase_timer.sv - holds each light phase for its programmed time, then pulses advance
module traffic_phase_timer
   import traffic_pkg::*;
#(
   parameter int TICK_DIV     = 100_000_000,
   parameter int GREEN_S      = 10,
   parameter int YELLOW_S     = 3,
   parameter int ALLRED_S     = 2,
   parameter int PED_S        = 8,
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int WAIT_LIMIT   = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       MG,
   input  logic       MY,
   input  logic       MR,
   input  logic       SG,
   input  logic       SY,
   input  logic       SR,
   input  logic       pedLight,
   input  logic       pedButton,
   output logic       advance,
   output logic       pedReq,
   output logic [7:0] remaining,
   output logic       fault
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int WW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

   logic [6:0]    lightMeta;
   logic [6:0]    lightSync;
   phase_class_e  lightClass;
   phase_class_e  prevClass;
   timer_state_e  state;
   timer_state_e  stateNext;
   logic [1:0]    settleCnt;
   logic [PW-1:0] prescaler;
   logic [WW-1:0] waitCnt;
   logic [7:0]    duration;
   logic          tick;
   logic          classChanged;
   logic          waitDone;
   logic          advanceNext;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lightMeta <= '0;
         lightSync <= '0;
      end else begin
         lightMeta <= {MG, MY, MR, SG, SY, SR, pedLight};
         lightSync <= lightMeta;
      end
   end

   assign lightClass   = decodeClass(lightSync);
   assign classChanged = (lightClass != prevClass);
   assign tick         = (prescaler == PW'(TICK_DIV - 1));
   assign waitDone     = (waitCnt == WW'(WAIT_LIMIT - 1));

   always_comb begin
      duration = clampDur(ALLRED_S);
      case (lightClass)
         GREEN:   duration = clampDur(GREEN_S);
         YELLOW:  duration = clampDur(YELLOW_S);
         PED:     duration = clampDur(PED_S);
         default: duration = clampDur(ALLRED_S);
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= SETTLE;
      else
         state <= stateNext;
   end

   always_comb begin
      stateNext   = state;
      advanceNext = 1'b0;
      case (state)
         SETTLE:   if (settleCnt == 2'(SETTLE_CYC - 1)) stateNext = LOAD;
         LOAD:     stateNext = COUNT;
         COUNT: begin
            // An external restart of the light machine aborts the phase without a pulse.
            if (classChanged) begin
               stateNext = LOAD;
            end else if (tick && remaining <= 8'd1) begin
               stateNext   = WAIT_CHG;
               advanceNext = 1'b1;
            end
         end
         WAIT_CHG: if (classChanged || waitDone) stateNext = LOAD;
         default:  stateNext = SETTLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         settleCnt <= '0;
         prescaler <= '0;
         waitCnt   <= '0;
         remaining <= '0;
         prevClass <= GREEN;
         advance   <= 1'b0;
         fault     <= 1'b0;
      end else begin
         advance <= advanceNext;
         case (state)
            SETTLE: settleCnt <= settleCnt + 2'd1;
            LOAD: begin
               remaining <= duration;
               prescaler <= '0;
               prevClass <= lightClass;
               if (lightClass == INVALID) fault <= 1'b1;
            end
            COUNT: begin
               waitCnt <= '0;
               if (!classChanged) begin
                  if (tick) begin
                     prescaler <= '0;
                     remaining <= (remaining > 8'd1) ? remaining - 8'd1 : 8'd0;
                  end else begin
                     prescaler <= prescaler + PW'(1);
                  end
               end
            end
            WAIT_CHG: begin
               waitCnt <= waitCnt + WW'(1);
               // A stalled light machine is flagged and the same phase is retried.
               if (waitDone && !classChanged) fault <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   ped_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
   ) pedDebounce (
      .clk      (clk),
      .reset    (reset),
      .pedButton(pedButton),
      .clear    (lightSync[0]),
      .pedReq   (pedReq)
   );

endmodule

// File: tb/tb_traffic_phase_timer.sv
// tb/tb_traffic_phase_timer.sv - directed self-checking bench for traffic_phase_timer
module tb_traffic_phase_timer;

   localparam int TD = 4;
   // {MG, MY, MR, SG, SY, SR, pedLight}
   localparam logic [6:0] L_GR  = 7'b1000010;
   localparam logic [6:0] L_YR  = 7'b0100010;
   localparam logic [6:0] L_RR  = 7'b0010010;
   localparam logic [6:0] L_RG  = 7'b0011000;
   localparam logic [6:0] L_RY  = 7'b0010100;
   localparam logic [6:0] L_PED = 7'b0010011;
   localparam logic [6:0] L_OFF = 7'b0000000;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pedButton = 1'b0;
   logic [6:0] lights;
   logic [6:0] nextLights;
   logic       modelOn;
   logic       advance;
   logic       pedReq;
   logic       fault;
   logic [7:0] remaining;
   int         nAssert = 0;
   int         nFail = 0;

   always #5 clk = ~clk;

   traffic_phase_timer #(
      .TICK_DIV(TD), .GREEN_S(3), .YELLOW_S(2), .ALLRED_S(1), .PED_S(2),
      .DEBOUNCE_CYC(3), .WAIT_LIMIT(8)
   ) dut (
      .clk(clk), .reset(reset),
      .MG(lights[6]), .MY(lights[5]), .MR(lights[4]),
      .SG(lights[3]), .SY(lights[2]), .SR(lights[1]),
      .pedLight(lights[0]), .pedButton(pedButton),
      .advance(advance), .pedReq(pedReq), .remaining(remaining), .fault(fault)
   );

   // Light state machine model: steps to nextLights when it sees advance.
   task automatic tick();
      @(negedge clk);
      if (modelOn && advance === 1'b1) lights = nextLights;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp)
      else begin
         nFail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic phase(input string tag, input int dur);
      int n = 0;
      tick();
      chk({tag, " single pulse"}, 32'(advance), 32'd0);
      while (remaining == 8'd0 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, " load"}, 32'(remaining), 32'(dur));
      for (int i = 1; i <= dur * TD; i++) begin
         tick();
         chk({tag, " advance"}, 32'(advance), 32'(i == dur * TD));
         if (i % TD == 0) chk({tag, " remaining"}, 32'(remaining), 32'(dur - i / TD));
      end
   endtask

   task automatic waitAdv(input string tag, input int limit);
      int n = 0;
      do begin
         tick();
         n++;
      end while (advance !== 1'b1 && n < limit);
      chk({tag, " advance seen"}, 32'(advance), 32'd1);
   endtask

   task automatic press(input string tag, input logic expReq);
      pedButton = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 5) chk({tag, " req before"}, 32'(pedReq), 32'd0);
         if (i == 6) chk({tag, " req after"}, 32'(pedReq), 32'(expReq));
      end
      pedButton = 1'b0;
   endtask

   initial begin
      int n;
      lights     = L_GR;
      nextLights = L_YR;
      modelOn    = 1'b1;
      repeat (2) tick();
      chk("reset advance", 32'(advance), 32'd0);
      chk("reset pedReq", 32'(pedReq), 32'd0);
      chk("reset remaining", 32'(remaining), 32'd0);
      chk("reset fault", 32'(fault), 32'd0);
      reset = 1'b0;

      // Normal sequencing GR -> YR -> RR -> RG
      phase("grn", 3);
      nextLights = L_RR;
      phase("yel", 2);
      nextLights = L_RG;
      phase("allred", 1);

      // Button glitch, then a clean press during the RG green
      nextLights = L_RY;
      pedButton = 1'b1;
      repeat (2) tick();
      pedButton = 1'b0;
      repeat (4) tick();
      chk("glitch ignored", 32'(pedReq), 32'd0);
      press("press", 1'b1);
      waitAdv("rg", 20);
      nextLights = L_PED;
      waitAdv("ry", 30);
      chk("req held", 32'(pedReq), 32'd1);
      repeat (2) tick();
      chk("req before clear", 32'(pedReq), 32'd1);
      tick();
      chk("req cleared", 32'(pedReq), 32'd0);

      // Press while pedLight is on is dropped; a later press latches
      nextLights = L_GR;
      press("ped press", 1'b0);
      waitAdv("ped", 10);
      repeat (6) tick();
      chk("ped press dropped", 32'(pedReq), 32'd0);
      modelOn = 1'b0;
      press("new press", 1'b1);

      // Stalled light machine
      waitAdv("stall", 20);
      repeat (7) tick();
      chk("fault pre", 32'(fault), 32'd0);
      tick();
      chk("fault timeout", 32'(fault), 32'd1);
      tick();
      chk("retry load", 32'(remaining), 32'd3);
      for (int i = 1; i <= 12; i++) begin
         tick();
         chk("retry advance", 32'(advance), 32'(i == 12));
      end

      // Async reset mid-COUNT
      lights = L_YR;
      n = 0;
      while (remaining == 8'd0 && n < 20) begin
         tick();
         n++;
      end
      tick();
      chk("pre-reset remaining", 32'(remaining), 32'd2);
      chk("pre-reset pedReq", 32'(pedReq), 32'd1);
      chk("pre-reset fault", 32'(fault), 32'd1);
      reset = 1'b1;
      #1;
      chk("async advance", 32'(advance), 32'd0);
      chk("async pedReq", 32'(pedReq), 32'd0);
      chk("async remaining", 32'(remaining), 32'd0);
      chk("async fault", 32'(fault), 32'd0);
      tick();
      reset = 1'b0;
      repeat (3) tick();
      chk("settle", 32'(remaining), 32'd0);
      tick();
      chk("reload after reset", 32'(remaining), 32'd2);

      // Invalid lights, then a light-machine restart during COUNT
      lights     = L_OFF;
      nextLights = L_OFF;
      modelOn    = 1'b1;
      n = 0;
      while (fault !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      chk("invalid fault", 32'(fault), 32'd1);
      chk("invalid load", 32'(remaining), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("invalid advance", 32'(advance), 32'(i == 4));
      end
      n = 0;
      while (remaining == 8'd0 && n < 20) begin
         tick();
         n++;
      end
      chk("invalid retry load", 32'(remaining), 32'd1);
      lights = L_GR;
      for (int i = 1; i <= 6; i++) begin
         tick();
         chk("restart no advance", 32'(advance), 32'd0);
         if (i == 3) chk("restart pending", 32'(remaining), 32'd1);
         if (i == 4) chk("restart reload", 32'(remaining), 32'd3);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
